// File: rtl/video_ntsc_pkg.sv
// Shared NTSC composite-encoder constants, stage-1 flag bundle and lock FSM encoding.
package video_ntsc_pkg;

  localparam int Y_W    = 8;
  localparam int UV_W   = 9;
  localparam int WDOG_W = 11;

  localparam logic [7:0] C_SYNC_LVL  = 8'd0;
  localparam logic [7:0] C_BLANK     = 8'd72;
  localparam logic [7:0] C_BURST_AMP = 8'd16;
  localparam logic [7:0] C_SETUP     = 8'd10;
  localparam logic [7:0] C_Y_GAIN    = 8'd179;
  localparam logic [7:0] C_U_GAIN    = 8'd63;
  localparam logic [7:0] C_V_GAIN    = 8'd112;

  // Must exceed one 780-pixel line so a healthy sync stream never times out.
  localparam logic [WDOG_W-1:0] C_LOCK_TO = 11'd1023;

  typedef enum logic {
    ST_MUTE = 1'b0,
    ST_RUN  = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic xsync;
    logic xblk;
    logic burst;
    logic sin_neg;
    logic cos_neg;
    logic kill;
  } s1_flags_t;

endpackage

// File: rtl/ntsc_rgb2yuv.sv
// Combinational RGB444 -> Y8 / U9 / V9 colour-space conversion feeding encoder stage 1.
module ntsc_rgb2yuv
  import video_ntsc_pkg::*;
(
  input  logic [3:0]             r_i,
  input  logic [3:0]             g_i,
  input  logic [3:0]             b_i,
  output logic [Y_W-1:0]         y_o,
  output logic signed [UV_W-1:0] u_o,
  output logic signed [UV_W-1:0] v_o
);

  // Weights 5/9/2 sum to 16, so Y8 peaks at 240 and fits 8 bits unsigned.
  assign y_o = 8'(r_i) * 8'd5 + 8'(g_i) * 8'd9 + 8'(b_i) * 8'd2;
  assign u_o = $signed({1'b0, b_i, 4'b0000}) - $signed({1'b0, y_o});
  assign v_o = $signed({1'b0, r_i, 4'b0000}) - $signed({1'b0, y_o});

endmodule

// File: rtl/ntsc_squ_encoder.sv
// Two-stage NTSC composite encoder with sync-lock mute. Define NTSC_SQU_SETUP_EN to add the
// 7.5 IRE pedestal to active video.
module ntsc_squ_encoder
  import video_ntsc_pkg::*;
(
  input  logic       CK_i,
  input  logic       RST_i,
  input  logic       XSYNC_i,
  input  logic       XBLK_i,
  input  logic       COLOR_BAR_NOW_i,
  input  logic [3:0] sin_s_i,
  input  logic [3:0] cos_s_i,
  input  logic [3:0] R_i,
  input  logic [3:0] G_i,
  input  logic [3:0] B_i,
  input  logic       COLOR_KILL_i,
  output logic [7:0] DAC_o,
  output logic       SYNC_LOCK_o,
  output logic       XBLK_o
);

`ifdef NTSC_SQU_SETUP_EN
  localparam logic signed [10:0] PEDESTAL = 11'(C_BLANK) + 11'(C_SETUP);
`else
  localparam logic signed [10:0] PEDESTAL = 11'(C_BLANK);
`endif
  localparam logic signed [17:0] U_GAIN_S = 18'(C_U_GAIN);
  localparam logic signed [17:0] V_GAIN_S = 18'(C_V_GAIN);

  s1_flags_t                s1_d, s1_q;
  logic                     xsync_prev_q;
  logic [Y_W-1:0]           y_d, y_q;
  logic signed [UV_W-1:0]   u_d, u_q, v_d, v_q;
  lock_state_e              state_d, state_q;
  logic [WDOG_W-1:0]        wdog_d, wdog_q, wdog_inc;
  logic [7:0]               dac_d, dac_q, active_code;
  logic                     xblk_q, fall;
  logic signed [17:0]       u_prod, v_prod, c_sum;
  logic signed [10:0]       chroma, total;
  logic [15:0]              y_prod;
  logic                     unused_phase_bits;

  // Only the sign bits of the square phase codes carry information.
  assign unused_phase_bits = ^{sin_s_i[2:0], cos_s_i[2:0]};

  ntsc_rgb2yuv u_rgb2yuv (
    .r_i (R_i),
    .g_i (G_i),
    .b_i (B_i),
    .y_o (y_d),
    .u_o (u_d),
    .v_o (v_d)
  );

  always_comb begin
    s1_d = '{xsync: XSYNC_i, xblk: XBLK_i, burst: COLOR_BAR_NOW_i,
             sin_neg: sin_s_i[3], cos_neg: cos_s_i[3], kill: COLOR_KILL_i};
  end

  // Active-video level: luma plus signed square-subcarrier chroma, clamped above sync tip.
  always_comb begin
    u_prod = 18'(u_q) * U_GAIN_S;
    v_prod = 18'(v_q) * V_GAIN_S;
    c_sum  = (s1_q.sin_neg ? -u_prod : u_prod) + (s1_q.cos_neg ? -v_prod : v_prod);
    chroma = s1_q.kill ? 11'sd0 : 11'(c_sum >>> 8);
    y_prod = 16'(y_q) * 16'(C_Y_GAIN);
    total  = PEDESTAL + $signed({3'b000, y_prod[15:8]}) + chroma;
    if (total < 11'sd1)        active_code = 8'd1;
    else if (total > 11'sd255) active_code = 8'd255;
    else                       active_code = total[7:0];
  end

  // Lock FSM and watchdog; a fall in the same cycle as the timeout keeps the lock.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    wdog_d   = wdog_q;
    wdog_inc = wdog_q + 11'd1;
    fall     = xsync_prev_q & ~s1_q.xsync;
    case (state_q)
      ST_MUTE: begin
        if (fall) begin
          state_d = ST_RUN;
          wdog_d  = '0;
        end
      end
      ST_RUN: begin
        if (fall) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == C_LOCK_TO) state_d = ST_MUTE;
        end
      end
      default: state_d = ST_MUTE;
    endcase
  end

  // Mute uses the next state so the locking sync sample is the first level emitted.
  always_comb begin
    dac_d = C_BLANK;
    if (state_d == ST_MUTE) begin
      dac_d = C_BLANK;
    end else if (!s1_q.xsync) begin
      dac_d = C_SYNC_LVL;
    end else if (!s1_q.xblk) begin
      if (s1_q.burst && !s1_q.kill)
        dac_d = s1_q.sin_neg ? (C_BLANK + C_BURST_AMP) : (C_BLANK - C_BURST_AMP);
    end else begin
      dac_d = active_code;
    end
  end

  always_ff @(posedge CK_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (RST_i) begin
      s1_q         <= '0;
      xsync_prev_q <= 1'b0;
      state_q      <= ST_MUTE;
      wdog_q       <= '0;
      dac_q        <= C_BLANK;
      xblk_q       <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      xsync_prev_q <= s1_q.xsync;
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      dac_q        <= dac_d;
      xblk_q       <= s1_q.xblk;
    end
  end

  // NOTE: pixel datapath regs are left unreset; their output is masked by the cleared flags.
  always_ff @(posedge CK_i) begin
    y_q <= y_d;
    u_q <= u_d;
    v_q <= v_d;
  end

  assign DAC_o       = dac_q;
  assign SYNC_LOCK_o = (state_q == ST_RUN);
  assign XBLK_o      = xblk_q;

endmodule
